add_operand_pair: RTL
=====================

Name: add_operand_pair

Overview:
- Upstream stage of the 64-bit adder.
- Accepts a valid/ready stream of single W-bit words and pairs consecutive words into registered operands `a` and `b`.
- Presents each pair with a valid/ready handshake, so the adder sees stable register-driven inputs.
- An odd-length burst, marked by `in_last`, is closed by padding `b` with zero.

Parameters:
- W, 64, operand and data width
- CW, 16, width of the saturating pair counter

Ports:
- clk         input   1    clock; all state updates on the rising edge
- reset       input   1    synchronous, active-high reset
- in_data     input   W    incoming word
- in_valid    input   1    in_data is valid
- in_last     input   1    final word of a burst; qualified by in_valid
- in_ready    output  1    stage accepts a word this cycle
- a           output  W    first operand of the current pair (registered)
- b           output  W    second operand of the current pair (registered)
- pair_valid  output  1    a/b hold a complete pair
- pair_last   output  1    this pair closes a burst
- pair_odd    output  1    b is zero-padded (burst had an odd word count)
- pair_ready  input   1    downstream consumes the pair this cycle
- pair_count  output  CW   number of pairs handed off since reset, saturating

Behaviour:
- Word handshake: a word is accepted when `in_valid & in_ready`. Pair handshake: a pair is consumed when `pair_valid & pair_ready`. In any cycle where `in_ready=0`, `in_data` and `in_last` are ignored.
- Reset, applied at the clock edge:
  - state goes to S_A
  - a, b, pair_count, pair_last, pair_odd all go to 0
  - pair_valid=0
  - Reset takes priority over every other event.
- States:
  - S_A (waiting for the first operand):
    - in_ready=1, pair_valid=0.
    - On accept with in_last=0: a<=in_data; go to S_B.
    - On accept with in_last=1: a<=in_data, b<=0, pair_last<=1, pair_odd<=1; go to S_OUT.
  - S_B (holding a, waiting for the second operand):
    - in_ready=1, pair_valid=0.
    - On accept: b<=in_data, pair_last<=in_last, pair_odd<=0; go to S_OUT.
  - S_OUT (pair presented):
    - pair_valid=1, in_ready=pair_ready (combinational pass-through).
    - a, b, pair_last and pair_odd are held stable while pair_ready=0.
    - On pair consume with no word accepted: go to S_A. a and b keep their last values; they are don't-care while pair_valid=0.
    - On pair consume with a word accepted in the same cycle: that word is loaded per the S_A rules. The next state is S_B, or S_OUT if in_last=1.
- Latency: pair_valid rises in the cycle after the second word (or a lone last word) is accepted.
- Throughput: one word per cycle sustained when pair_ready is held at 1, which gives one pair every 2 cycles.
- pair_count:
  - Increments by 1 on each pair consume.
  - Saturates at 2^CW-1 and does not wrap.
- Boundary cases:
  - in_last on the second word of a pair: pair_last=1, pair_odd=0.
  - in_last held high across bursts: every burst closes independently; there is no carry-over between bursts.
  - Reset mid-pair: a buffered first operand is discarded and is never presented.
  - Reset while a pair is presented: pair_valid drops the next cycle and the count does not increment.
  - pair_ready asserted while pair_valid=0: no effect.

Decomposition:
- Shared package `add_pkg`:
  - default width constant W=64
  - state enum: S_A, S_B, S_OUT
- No sub-module: the FSM, operand registers and counter are one module.
- The combinational adder is instantiated by the parent and connects directly to a and b.

Test Plan:
- Reset, then stream 1, 2 with pair_ready=1:
  - pair_valid=1 with a=1, b=2, pair_last=0 one cycle after word 2 is accepted.
  - pair_count=1 after the consume.
- Stream 0xFFFF_FFFF_FFFF_FFFF, then 5 with in_last=1 → a=0xFFFF_FFFF_FFFF_FFFF, b=5, pair_last=1, pair_odd=0.
- Odd burst 7, 8, 9(last):
  - pairs (7,8) then (9,0).
  - The second pair has pair_last=1, pair_odd=1; pair_count=2.
- Backpressure:
  - Hold pair_ready=0 for 4 cycles with pair (3,4) presented; in_valid stays high with next word 10.
  - Required: in_ready=0 and a/b stable at 3/4 for all 4 cycles.
  - Word 10 is accepted in the same cycle pair_ready rises.
- Reset mid-pair:
  - Accept word 11, assert reset, then stream 12, 13.
  - The first pair presented is (12,13); 11 never appears.
- Saturation: force CW=4 and stream 40 words with pair_ready=1 → pair_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared constants and state encoding for the adder operand stage
//
// Purpose: default data width, default pair-counter width and the FSM state
// enum used by the operand-pairing stage in front of the 64-bit adder.
// Ports: none (package).
package add_pkg;

  localparam int W  = 64;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    S_A   = 2'd0,  // waiting for the first operand
    S_B   = 2'd1,  // holding a, waiting for the second operand
    S_OUT = 2'd2   // pair presented downstream
  } state_t;

endpackage

// File: rtl/add_operand_pair_if.sv
// rtl/add_operand_pair_if.sv - word-in / pair-out handshake bundle for the operand stage
//
// Purpose: groups the incoming word stream and the outgoing operand pair.
// Signals:
//   in_data/in_valid/in_last  word stream from upstream (driven by master)
//   in_ready                  stage accepts a word this cycle (driven by slave)
//   a/b                       registered operands (driven by slave)
//   pair_valid/last/odd       pair qualifiers (driven by slave)
//   pair_ready                downstream consumes the pair (driven by master)
// Modports: master = environment around the stage, slave = the stage itself.
interface add_operand_pair_if #(
  parameter int W = add_pkg::W
);

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         pair_valid;
  logic         pair_last;
  logic         pair_odd;
  logic         pair_ready;

  modport master (
    output in_data, in_valid, in_last, pair_ready,
    input  in_ready, a, b, pair_valid, pair_last, pair_odd
  );

  modport slave (
    input  in_data, in_valid, in_last, pair_ready,
    output in_ready, a, b, pair_valid, pair_last, pair_odd
  );

endinterface

// File: rtl/add_operand_pair.sv
// rtl/add_operand_pair.sv - pairs consecutive stream words into registered adder operands
//
// Purpose: accepts single W-bit words and presents them two at a time as
// register-driven operands a/b. A burst with an odd word count is closed by
// a pair whose b is zero. Counts consumed pairs with a saturating counter.
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   bus         slave side of add_operand_pair_if (word in, pair out)
//   pair_count  pairs handed off since reset, saturates at 2^CW-1
module add_operand_pair
  import add_pkg::*;
#(
  parameter int W  = add_pkg::W,
  parameter int CW = add_pkg::CW
) (
  input  logic          clk,
  input  logic          reset,
  add_operand_pair_if.slave bus,
  output logic [CW-1:0] pair_count
);

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         pair_valid_r;
  logic         pair_last_r;
  logic         pair_odd_r;

  logic accept;
  logic consume;

  // While a pair is presented a new word may only enter in the same cycle
  // the pair leaves, so readiness passes straight through from downstream.
  assign bus.in_ready = (state != S_OUT) | bus.pair_ready;

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = pair_valid_r & bus.pair_ready;

  assign bus.a          = a_r;
  assign bus.b          = b_r;
  assign bus.pair_valid = pair_valid_r;
  assign bus.pair_last  = pair_last_r;
  assign bus.pair_odd   = pair_odd_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_A;
      a_r          <= '0;
      b_r          <= '0;
      pair_valid_r <= 1'b0;
      pair_last_r  <= 1'b0;
      pair_odd_r   <= 1'b0;
      pair_count   <= '0;
    end else begin
      if (consume && (pair_count != {CW{1'b1}})) begin
        pair_count <= pair_count + 1'b1;
      end

      unique case (state)
        // S_OUT with a consume behaves exactly like S_A for the incoming
        // word; without a consume in_ready is low so accept cannot fire.
        S_A, S_OUT: begin
          if (accept) begin
            a_r <= bus.in_data;
            if (bus.in_last) begin
              // Lone last word: close the burst with a zero-padded pair.
              b_r          <= '0;
              pair_last_r  <= 1'b1;
              pair_odd_r   <= 1'b1;
              pair_valid_r <= 1'b1;
              state        <= S_OUT;
            end else begin
              pair_valid_r <= 1'b0;
              state        <= S_B;
            end
          end else if (consume) begin
            pair_valid_r <= 1'b0;
            state        <= S_A;
          end
        end

        S_B: begin
          if (accept) begin
            b_r          <= bus.in_data;
            pair_last_r  <= bus.in_last;
            pair_odd_r   <= 1'b0;
            pair_valid_r <= 1'b1;
            state        <= S_OUT;
          end
        end

        default: begin
          pair_valid_r <= 1'b0;
          state        <= S_A;
        end
      endcase
    end
  end

endmodule
